// File: rtl/maxpool_relu_tx.sv
// 2x2/stride-2 max-pool followed by ReLU on a three-channel raster pixel stream.
// The control FSM tracks row parity; each channel runs its own pair/row-buffer datapath.

module maxpool_relu_lane #(
    parameter int DATA_W = 12,
    parameter int HALF_W = 12,
    parameter int IW     = 4
) (
    input  logic              gclk,
    input  logic              rst_n,
    input  logic              load_pair,
    input  logic              wr_row,
    input  logic              emit,
    input  logic [IW-1:0]     col,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic signed [DATA_W-1:0] cur, pair_q, pair_max, rb_rd, pool_max;
    logic signed [DATA_W-1:0] row_buf [HALF_W];

    assign cur      = $signed(din);
    assign pair_max = (cur > pair_q) ? cur : pair_q;
    assign rb_rd    = row_buf[col];
    assign pool_max = (rb_rd > pair_max) ? rb_rd : pair_max;

    // Datapath storage needs no reset: every entry is rewritten before it is read.
    always_ff @(posedge gclk) begin
        if (load_pair) pair_q <= cur;
        if (wr_row)    row_buf[col] <= pair_max;
    end

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n)    dout <= '0;
        else if (emit) dout <= pool_max[DATA_W-1] ? '0 : pool_max;
    end
endmodule

module maxpool_relu_tx #(
    parameter int IN_WIDTH  = 24,
    parameter int IN_HEIGHT = 24,
    parameter int DATA_W    = 12
) (
    input  logic              gclk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] conv_out_1,
    input  logic [DATA_W-1:0] conv_out_2,
    input  logic [DATA_W-1:0] conv_out_3,
    output logic [DATA_W-1:0] max_value_1,
    output logic [DATA_W-1:0] max_value_2,
    output logic [DATA_W-1:0] max_value_3,
    output logic              valid_out,
    output logic              busy,
    output logic              frame_done
);
    localparam int NUM_LANES = 3;
    localparam int HALF_W    = IN_WIDTH / 2;
    localparam int IW        = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int XW        = IW + 1;
    localparam int YW        = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IN_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW} state_t;
    state_t state, state_nx;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          odd_row, x_last, y_last;
    logic          load_pair, wr_row, emit;
    logic [NUM_LANES-1:0][DATA_W-1:0] din, dout;

    assign odd_row   = (state == ODD_ROW);
    assign x_last    = (x == X_LAST);
    assign y_last    = (y == Y_LAST);
    assign load_pair = valid_in & ~x[0];
    assign wr_row    = valid_in &  x[0] & ~odd_row;
    assign emit      = valid_in &  x[0] &  odd_row;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (valid_in) state_nx = EVEN_ROW;
            EVEN_ROW: if (valid_in && x_last) state_nx = ODD_ROW;
            ODD_ROW:  if (valid_in && x_last) state_nx = y_last ? IDLE : EVEN_ROW;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            valid_out  <= emit;
            frame_done <= emit & x_last & y_last;
            if (valid_in) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    assign din = {conv_out_3, conv_out_2, conv_out_1};

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            maxpool_relu_lane #(.DATA_W(DATA_W), .HALF_W(HALF_W), .IW(IW)) u_lane (
                .gclk      (gclk),
                .rst_n     (rst_n),
                .load_pair (load_pair),
                .wr_row    (wr_row),
                .emit      (emit),
                .col       (x[XW-1:1]),
                .din       (din[g]),
                .dout      (dout[g])
            );
        end
    endgenerate

    assign max_value_1 = dout[0];
    assign max_value_2 = dout[1];
    assign max_value_3 = dout[2];
endmodule

// File: tb/tb_maxpool_relu_tx.sv
// Directed bench for maxpool_relu_tx: ramp/negative/window frames, gaps, mid-frame reset, back-to-back frames.
module tb_maxpool_relu_tx;
    logic        gclk, rst_n, valid_in;
    logic [11:0] conv_out_1, conv_out_2, conv_out_3;
    logic [11:0] max_value_1, max_value_2, max_value_3;
    logic        valid_out, busy, frame_done;

    maxpool_relu_tx #(.IN_WIDTH(24), .IN_HEIGHT(24), .DATA_W(12)) dut (
        .gclk(gclk), .rst_n(rst_n), .valid_in(valid_in),
        .conv_out_1(conv_out_1), .conv_out_2(conv_out_2), .conv_out_3(conv_out_3),
        .max_value_1(max_value_1), .max_value_2(max_value_2), .max_value_3(max_value_3),
        .valid_out(valid_out), .busy(busy), .frame_done(frame_done)
    );

    initial gclk = 0;
    always #5 gclk = ~gclk;

    typedef struct { int w[4]; int fill; int exp; } vec_t;
    typedef struct { int v1; int v2; int v3; int cyc; bit last; } exp_t;

    vec_t tbl[6];
    exp_t exp_q[$];
    exp_t e;
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, cur_vec = 0;
    int   out_idx = 0, pulses = 0, fd_cnt = 0;
    int   first1, first3, last1;
    int   hold1 = 0, hold2 = 0, hold3 = 0;
    bit   busy_exp = 0;

    always @(posedge gclk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int pix(input int ch, input int x, input int y);
        if (ch == 1) return y * 24 + x;
        if (ch == 2) return -100;
        if (x < 2 && y < 2) return tbl[cur_vec].w[y * 2 + x];
        return tbl[cur_vec].fill;
    endfunction

    function automatic int pool(input int ch, input int x, input int y);
        int m = pix(ch, x - 1, y - 1);
        if (pix(ch, x, y - 1) > m) m = pix(ch, x, y - 1);
        if (pix(ch, x - 1, y) > m) m = pix(ch, x - 1, y);
        if (pix(ch, x, y) > m)     m = pix(ch, x, y);
        return (m < 0) ? 0 : m;
    endfunction

    task automatic send_frame(input int gap_pct, input int npix);
        int n = 0;
        exp_t t;
        for (int y = 0; y < 24; y++) begin
            for (int x = 0; x < 24; x++) begin
                if (n >= npix) begin valid_in = 0; return; end
                while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                    valid_in = 0;
                    @(posedge gclk); #1;
                end
                valid_in   = 1;
                conv_out_1 = 12'(pix(1, x, y));
                conv_out_2 = 12'(pix(2, x, y));
                conv_out_3 = 12'(pix(3, x, y));
                @(posedge gclk);
                if ((x % 2) == 1 && (y % 2) == 1) begin
                    t.v1 = pool(1, x, y); t.v2 = pool(2, x, y); t.v3 = pool(3, x, y);
                    t.cyc = cyc; t.last = (x == 23 && y == 23);
                    exp_q.push_back(t);
                end
                if (x == 0 && y == 0) busy_exp = 1;
                if (x == 23 && y == 23) busy_exp = 0;
                n++;
                #1;
            end
        end
        valid_in = 0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin @(negedge gclk); #1; k++; end
        check("drain_pending", exp_q.size(), 0);
        @(posedge gclk); #1;
    endtask

    always @(negedge gclk) begin
        if (rst_n) begin
            if (valid_out) begin
                if (exp_q.size() == 0) check("spurious_valid_out", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("ch1", int'($signed(max_value_1)), e.v1);
                    check("ch2", int'($signed(max_value_2)), e.v2);
                    check("ch3", int'($signed(max_value_3)), e.v3);
                    check("latency", cyc, e.cyc + 1);
                    check("frame_done", int'(frame_done), int'(e.last));
                    if (out_idx == 0) begin
                        first1 = int'($signed(max_value_1));
                        first3 = int'($signed(max_value_3));
                    end
                    out_idx++;
                    if (e.last) begin last1 = int'($signed(max_value_1)); out_idx = 0; end
                end
                pulses++;
                hold1 = int'($signed(max_value_1));
                hold2 = int'($signed(max_value_2));
                hold3 = int'($signed(max_value_3));
            end else begin
                check("hold1", int'($signed(max_value_1)), hold1);
                check("hold2", int'($signed(max_value_2)), hold2);
                check("hold3", int'($signed(max_value_3)), hold3);
                check("fd_without_vo", int'(frame_done), 0);
            end
            check("busy", int'(busy), int'(busy_exp));
            if (frame_done) fd_cnt++;
        end
    end

    task automatic check_ramp_frame(input int vec);
        check("ramp_first", first1, 25);
        check("ramp_last", last1, 575);
        check("ch3_first_window", first3, tbl[vec].exp);
    endtask

    initial begin
        tbl[0] = '{w: '{-5, -3, -7, -1},             fill: -9,   exp: 0};
        tbl[1] = '{w: '{-2048, 2047, 0, -1},         fill: -9,   exp: 2047};
        tbl[2] = '{w: '{-1, -2, -3, -4},             fill: 5,    exp: 0};
        tbl[3] = '{w: '{100, -100, 99, 101},         fill: -9,   exp: 101};
        tbl[4] = '{w: '{7, 7, 7, 7},                 fill: 2047, exp: 7};
        tbl[5] = '{w: '{-2048, -2048, -2048, -2048}, fill: 1,    exp: 0};

        rst_n = 0; valid_in = 0;
        conv_out_1 = '0; conv_out_2 = '0; conv_out_3 = '0;
        #12;
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_max1", int'(max_value_1), 0);
        check("rst_max3", int'(max_value_3), 0);
        rst_n = 1;
        @(posedge gclk); #1;

        for (int i = 0; i < 6; i++) begin
            cur_vec = i;
            send_frame(0, 576);
            drain();
            check_ramp_frame(i);
        end

        cur_vec = 0;
        send_frame(50, 576);
        drain();
        check_ramp_frame(0);

        send_frame(0, 300);
        #2 rst_n = 0;
        exp_q.delete();
        busy_exp = 0; out_idx = 0; hold1 = 0; hold2 = 0; hold3 = 0;
        #1;
        check("midrst_valid_out", int'(valid_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_max1", int'(max_value_1), 0);
        check("midrst_max2", int'(max_value_2), 0);
        @(posedge gclk); #1 rst_n = 1;
        @(posedge gclk); #1;
        send_frame(0, 576);
        drain();
        check_ramp_frame(0);

        pulses = 0; fd_cnt = 0;
        send_frame(0, 576);
        send_frame(0, 576);
        drain();
        check("b2b_pulses", pulses, 288);
        check("b2b_frame_done", fd_cnt, 2);
        check_ramp_frame(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/maxpool_relu_tx.md
MAXPOOL_RELU_TX -- requirements
Module: maxpool_relu_tx

Interface
REQ-001 Parameter: IN_WIDTH, default 24, input feature-map columns; SHALL be even.
REQ-002 Parameter: IN_HEIGHT, default 24, input feature-map rows; SHALL be even.
REQ-003 Parameter: DATA_W, default 12, signed sample width.
REQ-004 gclk  input  1  clock; all state SHALL update on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 valid_in  input  1  one raster-order pixel (all 3 channels) presented this cycle.
REQ-007 conv_out_1, conv_out_2, conv_out_3  input  DATA_W each  signed conv1 samples, channels 1-3.
REQ-008 max_value_1, max_value_2, max_value_3  output  DATA_W each  pooled, ReLU'd samples; registered.
REQ-009 valid_out  output  1  max_value_* valid this cycle; single-cycle pulse per pooled pixel.
REQ-010 busy  output  1  frame in progress.
REQ-011 frame_done  output  1  single-cycle pulse with last pooled pixel of frame.

Function
REQ-012 Block SHALL perform 2x2 max-pool, stride 2, per channel independently, then ReLU (negative -> 0), emitting (IN_WIDTH/2)x(IN_HEIGHT/2) pixels per frame in raster order.
REQ-013 Input pixel (x,y) SHALL be tracked by column counter x (0..IN_WIDTH-1) and row counter y (0..IN_HEIGHT-1); counters advance only on valid_in; x wraps to 0 and y increments after x=IN_WIDTH-1.
REQ-014 valid_in gaps of any length SHALL be tolerated; no state changes while valid_in=0 except output pulses clearing.
REQ-015 FSM states: IDLE, EVEN_ROW, ODD_ROW.
REQ-016 IDLE -> EVEN_ROW on first valid_in (that sample is pixel (0,0) and is consumed); busy SHALL rise the cycle after.
REQ-017 EVEN_ROW -> ODD_ROW on accepting x=IN_WIDTH-1 of an even row; ODD_ROW -> EVEN_ROW on accepting x=IN_WIDTH-1 of an odd row other than last; ODD_ROW -> IDLE on accepting (IN_WIDTH-1, IN_HEIGHT-1).
REQ-018 Even column sample SHALL be held in a per-channel pair register; on odd column, pair max = signed max(held, current).
REQ-019 Even row, odd column: pair max SHALL be written to per-channel row buffer entry x/2 (IN_WIDTH/2 entries x DATA_W x 3 channels).
REQ-020 Odd row, odd column: result = signed max(row buffer[x/2], pair max); max_value_n SHALL be result if result[DATA_W-1]=0, else 0.
REQ-021 Latency: valid_out SHALL assert exactly one cycle after the gclk edge accepting the odd-row odd-column sample.
REQ-022 max_value_* SHALL hold last emitted value while valid_out=0.
REQ-023 Comparisons SHALL be two's-complement signed; equal values select either (identical result); no saturation or width growth.
REQ-024 frame_done SHALL assert in the same cycle as the final valid_out of frame; busy SHALL deassert that same cycle.
REQ-025 valid_in in the cycle after frame_done SHALL be accepted as (0,0) of next frame; back-to-back frames SHALL require no idle cycle.
REQ-026 Row buffer entries SHALL be overwritten each even row; stale values SHALL never reach outputs.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, x=0, y=0, valid_out=0, busy=0, frame_done=0, max_value_*=0; row buffer and pair registers need not be cleared.
REQ-028 Reset mid-frame SHALL discard partial frame; first valid_in after release is pixel (0,0).

Verification
REQ-029 Ramp frame: ch1 pixel=(y*24+x), continuous valid_in -> 144 valid_out pulses; first max_value_1=25, last=575; frame_done with 144th pulse.
REQ-030 All-negative frame (ch2=-100 everywhere) -> all 144 max_value_2=0; one window (0,0..1,1) = {-5,-3,-7,-1} on ch3 with others -9 -> first max_value_3=0.
REQ-031 Signed max: window {-2048, 2047, 0, -1} -> 2047; window {-1,-2,-3,-4} -> 0.
REQ-032 Random valid_in gaps (50% duty) on ramp frame -> identical output sequence to REQ-029; each valid_out 1 cycle after its odd/odd accept.
REQ-033 Reset asserted after 300 accepted pixels, release, full ramp frame -> outputs exactly as REQ-029, no residue.
REQ-034 Two back-to-back frames, valid_in continuous -> 288 pulses, two frame_done pulses, busy low only in cycle(s) after each frame_done until next accept.
